// File: rtl/vga_sync_if.sv
// Timing bus from vga_sync to the pixel-producing blocks.
// vga_sync drives it through the master modport; consumers read it through the slave modport.
interface vga_sync_if;
   logic [9:0] HCount;
   logic [9:0] VCount;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic       pixel_tick;
   logic       frame_tick;

   modport master (
      output HCount, VCount, hsync, vsync, video_on, pixel_tick, frame_tick
   );

   modport slave (
      input  HCount, VCount, hsync, vsync, video_on, pixel_tick, frame_tick
   );
endinterface

// File: rtl/vga_sync.sv
// VGA timing generator: halves clk into a pixel enable and produces the pixel counters,
// the active-low syncs, the visible-area flag and a one-clk end-of-frame pulse.
module vga_sync #(
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic       clk,
   input  logic       reset,
   vga_sync_if.master vga
);

   localparam int unsigned HTotal = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned VTotal = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] HMax       = 10'(HTotal - 1);
   localparam logic [9:0] VMax       = 10'(VTotal - 1);
   localparam logic [9:0] HVisible   = 10'(H_DISPLAY);
   localparam logic [9:0] VVisible   = 10'(V_DISPLAY);
   localparam logic [9:0] HSyncFirst = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HSyncLast  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VSyncFirst = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VSyncLast  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic       div_q, div_d;
   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       pixel_tick;
   logic       h_at_max;
   logic       v_at_max;

   assign pixel_tick = div_q;
   assign h_at_max   = (h_q == HMax);
   assign v_at_max   = (v_q == VMax);

   always_comb begin
      div_d = ~div_q;
      h_d   = h_q;
      v_d   = v_q;
      if (pixel_tick) begin
         if (h_at_max) begin
            h_d = '0;
            v_d = v_at_max ? '0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
      end
      // Syncs decode the next counter values so they land on the same edge as the counters.
      hsync_d = ~((h_d >= HSyncFirst) && (h_d <= HSyncLast));
      vsync_d = ~((v_d >= VSyncFirst) && (v_d <= VSyncLast));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q   <= 1'b0;
         h_q     <= '0;
         v_q     <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
      end else begin
         div_q   <= div_d;
         h_q     <= h_d;
         v_q     <= v_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign vga.HCount     = h_q;
   assign vga.VCount     = v_q;
   assign vga.hsync      = hsync_q;
   assign vga.vsync      = vsync_q;
   assign vga.pixel_tick = pixel_tick;
   assign vga.video_on   = (h_q < HVisible) && (v_q < VVisible);
   assign vga.frame_tick = pixel_tick && h_at_max && v_at_max;

endmodule

// File: doc/vga_sync.md
# vga_sync

Timing generator for the 640x480 @ 60 Hz VGA output path. Divides the 50 MHz system clock down to a 25 MHz pixel enable. Produces the horizontal/vertical pixel counters consumed by the sprite and background generators, plus the monitor sync signals. Sits directly upstream of every pixel-producing block: their `HCount`/`VCount` inputs come from here.

## Interface
- `H_DISPLAY`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_DISPLAY`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)

Ports:
- `clk` in 1: 50 MHz system clock; all state on rising edge
- `reset` in 1: synchronous, active-high
- `HCount` out 10: current pixel column, 0..H_TOTAL-1
- `VCount` out 10: current line, 0..V_TOTAL-1
- `hsync` out 1: horizontal sync, active-low
- `vsync` out 1: vertical sync, active-low
- `video_on` out 1: high while (HCount, VCount) is in the visible area
- `pixel_tick` out 1: one-clk enable, high every second clk
- `frame_tick` out 1: one-clk pulse on the last pixel of a frame

## Operation
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800)
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525)
- 1-bit divider register toggles every clk.
  - `pixel_tick` = divider == 1; it is high on alternate cycles.
- Horizontal counter advances only on clk edges where `pixel_tick`=1.
  - HCount == H_TOTAL-1 → wraps to 0; otherwise +1.
- Vertical counter advances only when `pixel_tick`=1 and HCount == H_TOTAL-1.
  - VCount == V_TOTAL-1 → wraps to 0; otherwise +1.
- `hsync`, `vsync` are registers loaded from the *next* counter values, so they align cycle-exactly with `HCount`/`VCount`.
  - `hsync` = 0 iff H_DISPLAY+H_FRONT ≤ HCount ≤ H_DISPLAY+H_FRONT+H_SYNC-1, i.e. 656..751.
  - `vsync` = 0 iff V_DISPLAY+V_FRONT ≤ VCount ≤ V_DISPLAY+V_FRONT+V_SYNC-1, i.e. 490..491.
- `video_on` = (HCount < H_DISPLAY) && (VCount < V_DISPLAY). Combinational from the registered counters.
- `frame_tick` = `pixel_tick` && HCount == H_TOTAL-1 && VCount == V_TOTAL-1. Combinational; high for exactly one clk per frame, in the cycle before both counters wrap to 0.
- Counter width: 10 bits unsigned; must hold H_TOTAL-1. Comparisons are unsigned. Counters never exceed H_TOTAL-1 / V_TOTAL-1.

## Timing
- Reset values, applied on the clk edge where `reset`=1:
  - divider = 0, HCount = 0, VCount = 0
  - `hsync` = 1, `vsync` = 1
  - therefore `pixel_tick` = 0, `video_on` = 1, `frame_tick` = 0
- First edge after reset release: divider → 1. `pixel_tick` is high in the 2nd cycle after release. HCount becomes 1 at the edge that ends that cycle.
- Each (HCount, VCount) value is held for exactly 2 clk cycles.
- Line period: 1600 clk. Frame period: 840000 clk.
- Latency: counters → `video_on` is 0 cycles. `hsync`/`vsync` change on the same edge as the counter value that defines them.
- `reset` asserted mid-frame: all state returns to reset values on that edge, regardless of `pixel_tick`. While `reset` is held, outputs stay at reset values.
- Line wrap and frame wrap occur on the same edge when both counters are at max. VCount goes to 0, not 525.

## Test plan
- Reset: hold `reset` 3 clk mid-frame (e.g. at HCount=300, VCount=200) → HCount=0, VCount=0, `hsync`=1, `vsync`=1, `pixel_tick`=0, `video_on`=1 on the next edge and while held.
- Pixel rate: after release, `pixel_tick` pattern is 0,1,0,1…. HCount goes 0,0,1,1,2,2… per clk.
- Line wrap: HCount 799 → 0 on a `pixel_tick` edge. VCount increments by exactly 1 on that same edge. `video_on` low for HCount 640..799.
- Horizontal sync: `hsync` first low at HCount=656, last low at 751, high again at 752. Low duration is 192 clk.
- Vertical sync and frame: `vsync` low only for VCount 490..491 (3200 clk). `frame_tick` high for exactly one clk at (799,524). Successive `frame_tick` pulses are 840000 clk apart.
- Visible area: `video_on`=1 at (0,0) and (639,479); 0 at (640,0), (0,480) and (799,524).
